// File: rtl/acl_pkg.sv
// Shared constants and state type for the accelerometer SPI reader.
// Command bytes, register addresses, FSM states and tx byte lookup.
package acl_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h0A;
    localparam logic [7:0] CMD_READ     = 8'h0B;
    localparam logic [7:0] POWER_CTL    = 8'h2D;
    localparam logic [7:0] XDATA_L      = 8'h0E;
    localparam logic [7:0] YDATA_L      = 8'h10;
    localparam logic [7:0] ZDATA_L      = 8'h12;
    localparam logic [7:0] MEASURE_MODE = 8'h02;

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_GAP,
        ST_WAIT,
        ST_READ,
        ST_UPDATE
    } state_t;

    function automatic logic [7:0] axis_addr(input logic [1:0] axis);
        case (axis)
            2'b01:   return YDATA_L;
            2'b10:   return ZDATA_L;
            default: return XDATA_L;
        endcase
    endfunction

    // Byte idx of the write (rd=0) or read (rd=1) transaction.
    function automatic logic [7:0] tx_byte_of(
        input logic       rd,
        input logic [1:0] idx,
        input logic [1:0] axis
    );
        if (rd) begin
            case (idx)
                2'd0:    return CMD_READ;
                2'd1:    return axis_addr(axis);
                default: return 8'h00;
            endcase
        end
        case (idx)
            2'd0:    return CMD_WRITE;
            2'd1:    return POWER_CTL;
            2'd2:    return MEASURE_MODE;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Mode-0 SPI byte shifter: sclk/mosi generation, miso capture.
// Ports: start/tx_byte in; sclk, mosi, rx_byte, done out. done is
// high in the cycle before the last falling sclk edge; a start in
// that cycle chains the next byte with no gap.
module spi_byte_xfer #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    localparam int CW = $clog2(CLK_DIV);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          half_end;

    assign half_end = (cnt == CW'(CLK_DIV - 1));
    assign done     = busy && sclk && half_end && (bit_cnt == 3'd7);
    assign mosi     = busy && tx_sh[7];
    assign rx_byte  = rx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sclk    <= 1'b0;
        end else if (start && (!busy || done)) begin
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= tx_byte;
            sclk    <= 1'b0;
        end else if (busy) begin
            if (half_end) begin
                cnt  <= '0;
                sclk <= !sclk;
                if (!sclk) begin
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) busy <= 1'b0;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/acl_spi_reader.sv
// Configures the accelerometer, then periodically reads one axis.
// Ports: clk, rst_n, axis_sel, miso in; sclk, mosi, cs_n, sel_data,
// data_valid, init_done out.
module acl_spi_reader
    import acl_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] axis_sel,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [9:0] sel_data,
    output logic       data_valid,
    output logic       init_done
);

    // cs_n high time is counted from its rising edge, so it is the
    // same after the config write (GAP+WAIT) and after each read.
    localparam int GAP_LEN = CLK_DIV + SAMPLE_PERIOD;

    state_t      state, state_d;
    logic [31:0] cnt, cnt_d;
    logic        cs_n_d, tail, tail_d;
    logic [1:0]  idx, idx_d, axis, axis_d, last;
    logic [5:0]  lo, lo_d;
    logic [3:0]  hi, hi_d;
    logic [9:0]  sel_d;
    logic        valid_d, init_d, rd;
    logic        start, done;
    logic [7:0]  tx_byte, rx_byte;

    spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .rx_byte (rx_byte),
        .done    (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT_WR;
            cnt        <= '0;
            cs_n       <= 1'b1;
            tail       <= 1'b0;
            idx        <= '0;
            axis       <= '0;
            lo         <= '0;
            hi         <= '0;
            sel_data   <= '0;
            data_valid <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cs_n       <= cs_n_d;
            tail       <= tail_d;
            idx        <= idx_d;
            axis       <= axis_d;
            lo         <= lo_d;
            hi         <= hi_d;
            sel_data   <= sel_d;
            data_valid <= valid_d;
            init_done  <= init_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 32'd1;
        cs_n_d  = cs_n;
        tail_d  = tail;
        idx_d   = idx;
        axis_d  = axis;
        lo_d    = lo;
        hi_d    = hi;
        sel_d   = sel_data;
        valid_d = 1'b0;
        init_d  = init_done;
        start   = 1'b0;
        tx_byte = 8'h00;
        rd      = (state == ST_READ);
        last    = rd ? 2'd3 : 2'd2;
        unique case (state)
            ST_INIT_WR, ST_READ: begin
                if (cs_n) begin
                    start   = 1'b1;
                    tx_byte = tx_byte_of(rd, 2'd0, axis);
                    cs_n_d  = 1'b0;
                    idx_d   = 2'd0;
                end else if (tail) begin
                    // sclk is low; hold cs_n one more half-period
                    if (cnt == 32'(CLK_DIV - 1)) begin
                        cs_n_d = 1'b1;
                        tail_d = 1'b0;
                        cnt_d  = '0;
                        if (rd) begin
                            state_d = ST_UPDATE;
                        end else begin
                            state_d = ST_GAP;
                            init_d  = 1'b1;
                        end
                    end
                end else if (done) begin
                    if (rd && idx == 2'd2) lo_d = rx_byte[7:2];
                    if (rd && idx == 2'd3) hi_d = rx_byte[3:0];
                    if (idx == last) begin
                        tail_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        start   = 1'b1;
                        idx_d   = idx + 2'd1;
                        tx_byte = tx_byte_of(rd, idx + 2'd1, axis);
                    end
                end
            end
            ST_GAP: begin
                if (cnt == 32'(CLK_DIV - 1)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 32'(GAP_LEN - 1)) begin
                    state_d = ST_READ;
                    axis_d  = axis_sel;
                end
            end
            ST_UPDATE: begin
                sel_d   = {hi, lo};
                valid_d = 1'b1;
                state_d = ST_WAIT;
            end
            default: state_d = ST_INIT_WR;
        endcase
    end

endmodule
